// File: rtl/dma_desc_fetch.sv
// Descriptor-chain front end for one DMA channel: fetches 2-beat descriptors and sequences channel transfers.
// Optional irq output is enabled by defining DMA_DESC_IRQ_EN.
module dma_desc_fetch #(
  parameter int CHANNEL_ID = 0,
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 64
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  chain_start,
  input  logic [ADDR_WIDTH-1:0] chain_head_ptr,
  input  logic                  chain_abort,
  output logic [ADDR_WIDTH-1:0] desc_rd_addr,
  output logic                  desc_rd_valid,
  input  logic                  desc_rd_ready,
  input  logic [DATA_WIDTH-1:0] desc_rd_data,
  input  logic                  desc_rd_resp,
  output logic [ADDR_WIDTH-1:0] ch_src_addr,
  output logic [ADDR_WIDTH-1:0] ch_dst_addr,
  output logic [15:0]           ch_length,
  output logic                  ch_start,
  input  logic                  ch_done,
  input  logic                  ch_error,
  output logic                  chain_busy,
  output logic                  chain_done,
  output logic                  chain_error,
  output logic [1:0]            chain_err_code,
  output logic [15:0]           desc_count,
  output logic [7:0]            chain_id,
`ifdef DMA_DESC_IRQ_EN
  output logic                  irq,
`endif
  output logic [3:0]            dbg_state
);

  // Read handshake: a request is transferred on a cycle with desc_rd_valid && desc_rd_ready;
  // once raised, valid and addr hold until that cycle. One read is outstanding at a time.
  typedef enum logic [3:0] {
    IDLE  = 4'd0, REQ0  = 4'd1, WAIT0 = 4'd2, REQ1 = 4'd3, WAIT1 = 4'd4,
    CHECK = 4'd5, START = 4'd6, BUSY  = 4'd7, DONE = 4'd8, ERR   = 4'd9
  } state_t;

  state_t                state_q, state_d;
  logic [ADDR_WIDTH-1:0] ptr_q, src_q, dst_q, next_q;
  logic [15:0]           len_q, count_q;
  logic                  last_q, req_pend_q;
  logic [1:0]            code_q, code_d;

  always_comb begin
    state_d       = state_q;
    code_d        = code_q;
    desc_rd_valid = 1'b0;
    desc_rd_addr  = '0;
    case (state_q)
      IDLE: if (chain_start) begin
        code_d  = 2'd0;
        state_d = REQ0;
        if (chain_head_ptr[2:0] != 3'd0) begin
          state_d = ERR;
          code_d  = 2'd1;
        end
      end
      REQ0: begin
        desc_rd_addr = ptr_q;
        // Abort only before the request is shown; a presented request is held until accepted.
        if (!req_pend_q && chain_abort) begin
          state_d = ERR;
          code_d  = 2'd3;
        end else begin
          desc_rd_valid = 1'b1;
          if (desc_rd_ready) state_d = WAIT0;
        end
      end
      WAIT0: if (desc_rd_resp) state_d = REQ1;
      REQ1: begin
        desc_rd_addr  = ptr_q + ADDR_WIDTH'(8);
        desc_rd_valid = 1'b1;
        if (desc_rd_ready) state_d = WAIT1;
      end
      WAIT1: if (desc_rd_resp) state_d = CHECK;
      CHECK: begin
        if (len_q == 16'd0 || (!last_q && next_q[2:0] != 3'd0)) begin
          state_d = ERR;
          code_d  = 2'd1;
        end else if (chain_abort) begin
          state_d = ERR;
          code_d  = 2'd3;
        end else begin
          state_d = START;
        end
      end
      START: state_d = BUSY;
      BUSY: begin
        if (ch_error) begin
          state_d = ERR;
          code_d  = 2'd2;
        end else if (ch_done) begin
          if (chain_abort) begin
            state_d = ERR;
            code_d  = 2'd3;
          end else if (last_q) begin
            state_d = DONE;
          end else begin
            state_d = REQ0;
          end
        end
      end
      DONE:    state_d = IDLE;
      ERR:     state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

`ifdef DMA_DESC_IRQ_EN
  logic irq_q;
  logic unused_flags;
  assign unused_flags = ^desc_rd_data[47:34];
  assign irq = (state_q == BUSY && ch_done && !ch_error && irq_q) || state_q == ERR;
`else
  logic unused_flags;
  assign unused_flags = ^desc_rd_data[47:33];
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      code_q      <= 2'd0;
      req_pend_q  <= 1'b0;
      ptr_q       <= '0;
      src_q       <= '0;
      dst_q       <= '0;
      next_q      <= '0;
      len_q       <= 16'd0;
      last_q      <= 1'b0;
      count_q     <= 16'd0;
      ch_src_addr <= '0;
      ch_dst_addr <= '0;
      ch_length   <= 16'd0;
`ifdef DMA_DESC_IRQ_EN
      irq_q       <= 1'b0;
`endif
    end else begin
      state_q    <= state_d;
      code_q     <= code_d;
      req_pend_q <= desc_rd_valid && !desc_rd_ready;
      if (state_q == IDLE && chain_start) begin
        ptr_q   <= chain_head_ptr;
        count_q <= 16'd0;
      end
      if (state_q == WAIT0 && desc_rd_resp) begin
        src_q <= desc_rd_data[ADDR_WIDTH-1:0];
        dst_q <= desc_rd_data[32 +: ADDR_WIDTH];
      end
      if (state_q == WAIT1 && desc_rd_resp) begin
        len_q  <= desc_rd_data[15:0];
        last_q <= desc_rd_data[16];
        next_q <= desc_rd_data[32 +: ADDR_WIDTH];
`ifdef DMA_DESC_IRQ_EN
        irq_q  <= desc_rd_data[17];
`endif
      end
      // Channel fields change only when a validated descriptor is launched.
      if (state_q == CHECK && state_d == START) begin
        ch_src_addr <= src_q;
        ch_dst_addr <= dst_q;
        ch_length   <= len_q;
      end
      if (state_q == BUSY && ch_done && !ch_error) begin
        count_q <= count_q + 16'd1;
        ptr_q   <= next_q;
      end
    end
  end

  assign ch_start       = (state_q == START);
  assign chain_done     = (state_q == DONE);
  assign chain_error    = (state_q == ERR);
  assign chain_busy     = !(state_q == IDLE || state_q == DONE || state_q == ERR);
  assign chain_err_code = code_q;
  assign desc_count     = count_q;
  assign chain_id       = 8'(CHANNEL_ID);
  assign dbg_state      = state_q;

endmodule

// File: tb/tb_dma_desc_fetch.sv
// Bench for dma_desc_fetch: memory responder, channel model, table of chain scenarios, reset sequence.
`timescale 1ns/1ps
module tb_dma_desc_fetch;
  localparam int AW = 32;
  localparam logic [3:0] ST_WAIT1 = 4'd4;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          chain_start;
  logic [AW-1:0] chain_head_ptr;
  logic          chain_abort;
  logic [AW-1:0] desc_rd_addr;
  logic          desc_rd_valid;
  logic          desc_rd_ready;
  logic [63:0]   desc_rd_data;
  logic          desc_rd_resp;
  logic [AW-1:0] ch_src_addr, ch_dst_addr;
  logic [15:0]   ch_length;
  logic          ch_start, ch_done, ch_error;
  logic          chain_busy, chain_done, chain_error;
  logic [1:0]    chain_err_code;
  logic [15:0]   desc_count;
  logic [7:0]    chain_id;
  logic [3:0]    dbg_state;
`ifdef DMA_DESC_IRQ_EN
  logic          irq;
`endif

  dma_desc_fetch #(.CHANNEL_ID(0), .ADDR_WIDTH(AW), .DATA_WIDTH(64)) dut (
    .clk(clk), .rst_n(rst_n), .chain_start(chain_start), .chain_head_ptr(chain_head_ptr),
    .chain_abort(chain_abort), .desc_rd_addr(desc_rd_addr), .desc_rd_valid(desc_rd_valid),
    .desc_rd_ready(desc_rd_ready), .desc_rd_data(desc_rd_data), .desc_rd_resp(desc_rd_resp),
    .ch_src_addr(ch_src_addr), .ch_dst_addr(ch_dst_addr), .ch_length(ch_length),
    .ch_start(ch_start), .ch_done(ch_done), .ch_error(ch_error), .chain_busy(chain_busy),
    .chain_done(chain_done), .chain_error(chain_error), .chain_err_code(chain_err_code),
    .desc_count(desc_count), .chain_id(chain_id),
`ifdef DMA_DESC_IRQ_EN
    .irq(irq),
`endif
    .dbg_state(dbg_state)
  );

  always #5 clk = ~clk;

  typedef struct {
    int          ndesc;
    logic [31:0] head;
    int          dly;
    int          badlen_idx;
    int          badnext_idx;
    int          err_idx;
    int          both_idx;
    int          abort_idx;
    bit          abort_pre;
    bit          exp_done;
    logic [1:0]  exp_code;
    logic [15:0] exp_count;
    int          exp_starts;
    int          exp_reads;
  } vec_t;

  int checks = 0;
  int errors = 0;
  logic [63:0] mem [logic [31:0]];
  logic [31:0] addr_q[$];
  logic [79:0] exp_q[$];
  int max_dly = 0;
  int start_idx = 0;
  int err_idx = -1, both_idx = -1, abort_idx = -1;
  int irq_cnt = 0;
  bit in_flight = 1'b0;

  task automatic check(input string name, input logic [79:0] act, input logic [79:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  function automatic logic [63:0] rd(input logic [31:0] a);
    return mem.exists(a) ? mem[a] : 64'd0;
  endfunction

  function automatic vec_t mk(int nd, logic [31:0] hd, int dly, int bl, int bn, int er, int bo,
                              int ab, bit ap, bit d, logic [1:0] c, int cnt, int st, int rds);
    vec_t v;
    v.ndesc = nd; v.head = hd; v.dly = dly; v.badlen_idx = bl; v.badnext_idx = bn;
    v.err_idx = er; v.both_idx = bo; v.abort_idx = ab; v.abort_pre = ap; v.exp_done = d;
    v.exp_code = c; v.exp_count = 16'(cnt); v.exp_starts = st; v.exp_reads = rds;
    return v;
  endfunction

  // Memory read responder with random ready and response delays.
  initial begin
    desc_rd_ready = 1'b0;
    desc_rd_resp  = 1'b0;
    desc_rd_data  = '0;
    forever begin
      logic [31:0] a;
      int d;
      @(negedge clk);
      desc_rd_resp = 1'b0;
      if (desc_rd_valid === 1'b1 && rst_n === 1'b1) begin
        a = desc_rd_addr;
        if (in_flight) begin
          checks++; errors++;
          $display("FAIL read_while_busy actual addr=%0h required no read", a);
        end
        d = $urandom_range(0, max_dly);
        repeat (d) @(negedge clk);
        desc_rd_ready = 1'b1;
        @(negedge clk);
        desc_rd_ready = 1'b0;
        if (addr_q.size() == 0) begin
          checks++; errors++;
          $display("FAIL unexpected_read actual addr=%0h required none", a);
        end else begin
          check("rd_addr", 80'(a), 80'(addr_q.pop_front()));
        end
        d = $urandom_range(0, max_dly);
        repeat (d) @(negedge clk);
        desc_rd_data = rd(a);
        desc_rd_resp = 1'b1;
      end
    end
  end

  // Channel model: checks launched fields, then finishes with done, error or both.
  initial begin
    ch_done  = 1'b0;
    ch_error = 1'b0;
    forever begin
      int d;
      @(negedge clk);
      ch_done  = 1'b0;
      ch_error = 1'b0;
      if (ch_start === 1'b1) begin
        if (exp_q.size() == 0) begin
          checks++; errors++;
          $display("FAIL unexpected_ch_start actual src=%0h required none", ch_src_addr);
        end else begin
          check("ch_start_fields", {ch_src_addr, ch_dst_addr, ch_length}, exp_q.pop_front());
        end
        in_flight = 1'b1;
        if (start_idx == abort_idx) chain_abort = 1'b1;
        @(negedge clk);
        check("ch_start_one_cycle", 80'(ch_start), 80'(0));
        d = $urandom_range(0, max_dly);
        repeat (d) @(negedge clk);
        if (start_idx == both_idx) begin
          ch_done  = 1'b1;
          ch_error = 1'b1;
        end else if (start_idx == err_idx) begin
          ch_error = 1'b1;
        end else begin
          ch_done = 1'b1;
        end
        in_flight = 1'b0;
        start_idx++;
      end
    end
  end

`ifdef DMA_DESC_IRQ_EN
  initial begin
    forever begin
      @(negedge clk);
      #1;
      if (irq === 1'b1) begin
        irq_cnt++;
        check("irq_coincident", 80'((ch_done && !ch_error) || chain_error), 80'(1));
      end
    end
  end
`endif

  task automatic build(input vec_t v);
    logic [31:0] a, nxt, src, dst;
    logic [15:0] len, flags;
    mem.delete();
    addr_q.delete();
    exp_q.delete();
    for (int i = 0; i < v.ndesc; i++) begin
      a     = v.head + 32'h100 * i;
      nxt   = (i == v.ndesc - 1) ? 32'h0 : a + 32'h100;
      if (i == v.badnext_idx) nxt = nxt | 32'h4;
      flags = {14'd0, (i == 1), (i == v.ndesc - 1) && (i != v.badnext_idx)};
      src   = 32'h1000 * (i + 1);
      dst   = 32'h2000 + 32'h1000 * i;
      len   = (i == v.badlen_idx) ? 16'd0 : 16'(64 * (i + 1));
      mem[a]          = {dst, src};
      mem[a + 32'h8]  = {nxt, flags, len};
      if (i < v.exp_starts) exp_q.push_back({src, dst, len});
    end
    for (int k = 0; k < v.exp_reads; k++)
      addr_q.push_back(v.head + 32'h100 * (k / 2) + 32'h8 * (k % 2));
  endtask

  task automatic run_case(input vec_t v, input int n);
    bit fin;
    bit ok_head;
    build(v);
    max_dly   = v.dly;
    start_idx = 0;
    err_idx   = v.err_idx;
    both_idx  = v.both_idx;
    abort_idx = v.abort_idx;
    irq_cnt   = 0;
    ok_head   = (v.head[2:0] == 3'd0);
    @(negedge clk);
    chain_abort    = v.abort_pre;
    chain_head_ptr = v.head;
    chain_start    = 1'b1;
    @(negedge clk);
    chain_start = 1'b0;
    check($sformatf("c%0d_busy_after_start", n), 80'(chain_busy), 80'(ok_head));
    check($sformatf("c%0d_first_valid", n), 80'(desc_rd_valid), 80'(ok_head && !v.abort_pre));
    if (ok_head && !v.abort_pre)
      check($sformatf("c%0d_first_addr", n), 80'(desc_rd_addr), 80'(v.head));
    fin = 1'b0;
    for (int c = 0; c < 3000 && !fin; c++) begin
      if (chain_done || chain_error) fin = 1'b1;
      else @(negedge clk);
    end
    check($sformatf("c%0d_chain_end_seen", n), 80'(fin), 80'(1));
    check($sformatf("c%0d_done_err", n), {chain_done, chain_error}, {v.exp_done, !v.exp_done});
    check($sformatf("c%0d_err_code", n), 80'(chain_err_code), 80'(v.exp_code));
    check($sformatf("c%0d_desc_count", n), 80'(desc_count), 80'(v.exp_count));
    check($sformatf("c%0d_busy_at_end", n), 80'(chain_busy), 80'(0));
    @(negedge clk);
    check($sformatf("c%0d_end_pulse_width", n), 80'({chain_done, chain_error}), 80'(0));
    check($sformatf("c%0d_code_held", n), 80'(chain_err_code), 80'(v.exp_code));
    repeat (12) @(negedge clk);
    check($sformatf("c%0d_starts_left", n), 80'(exp_q.size()), 80'(0));
    check($sformatf("c%0d_reads_left", n), 80'(addr_q.size()), 80'(0));
`ifdef DMA_DESC_IRQ_EN
    check($sformatf("c%0d_irq_count", n), 80'(irq_cnt),
          80'((v.exp_count >= 16'd2 ? 1 : 0) + (v.exp_done ? 0 : 1)));
`endif
    chain_abort = 1'b0;
  endtask

  initial begin
    vec_t vecs[11];
    bit hit;
    vecs[0]  = mk(1, 32'h100,      0, -1, -1, -1, -1, -1, 0, 1, 2'd0, 1, 1, 2);
    vecs[1]  = mk(3, 32'h100,      5, -1, -1, -1, -1, -1, 0, 1, 2'd0, 3, 3, 6);
    vecs[2]  = mk(1, 32'h100,      0,  0, -1, -1, -1, -1, 0, 0, 2'd1, 0, 0, 2);
    vecs[3]  = mk(2, 32'h100,      2,  1, -1, -1, -1, -1, 0, 0, 2'd1, 1, 1, 4);
    vecs[4]  = mk(1, 32'h104,      2, -1, -1, -1, -1, -1, 0, 0, 2'd1, 0, 0, 0);
    vecs[5]  = mk(3, 32'h100,      3, -1, -1,  1, -1, -1, 0, 0, 2'd2, 1, 2, 4);
    vecs[6]  = mk(3, 32'h100,      1, -1, -1, -1,  1, -1, 0, 0, 2'd2, 1, 2, 4);
    vecs[7]  = mk(3, 32'h100,      4, -1, -1, -1, -1,  0, 0, 0, 2'd3, 1, 1, 2);
    vecs[8]  = mk(2, 32'h100,      2, -1, -1, -1, -1, -1, 1, 0, 2'd3, 0, 0, 0);
    vecs[9]  = mk(3, 32'h100,      2, -1,  0, -1, -1, -1, 0, 0, 2'd1, 0, 0, 2);
    vecs[10] = mk(1, 32'hFFFF_FFF8, 1, -1, -1, -1, -1, -1, 0, 1, 2'd0, 1, 1, 2);

    rst_n          = 1'b0;
    chain_start    = 1'b0;
    chain_head_ptr = '0;
    chain_abort    = 1'b0;
    repeat (3) @(negedge clk);
    check("reset_outputs_zero",
          80'(|{desc_rd_addr, desc_rd_valid, ch_src_addr, ch_dst_addr, ch_length, ch_start,
                chain_busy, chain_done, chain_error, chain_err_code, desc_count}), 80'(0));
    check("reset_chain_id", 80'(chain_id), 80'(0));
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    for (int i = 0; i < 11; i++) run_case(vecs[i], i);

    // Restart attempt mid-fetch is ignored; async reset in WAIT1 clears every output at once.
    build(vecs[0]);
    max_dly = 3;
    start_idx = 0; err_idx = -1; both_idx = -1; abort_idx = -1;
    @(negedge clk);
    chain_head_ptr = 32'h100;
    chain_start    = 1'b1;
    @(negedge clk);
    chain_start    = 1'b0;
    hit = 1'b0;
    for (int c = 0; c < 200 && !hit; c++) begin
      chain_start    = (c == 1);
      chain_head_ptr = (c == 1) ? 32'h800 : 32'h100;
      if (dbg_state == ST_WAIT1) hit = 1'b1;
      else @(negedge clk);
    end
    chain_start = 1'b0;
    check("reached_wait1", 80'(hit), 80'(1));
    check("restart_ignored_reads", 80'(addr_q.size()), 80'(0));
    rst_n = 1'b0;
    #1;
    check("async_reset_outputs_zero",
          80'(|{desc_rd_addr, desc_rd_valid, ch_src_addr, ch_dst_addr, ch_length, ch_start,
                chain_busy, chain_done, chain_error, chain_err_code, desc_count}), 80'(0));
    @(negedge clk);
    rst_n = 1'b1;
    exp_q.delete();
    repeat (12) @(negedge clk);
    check("idle_after_reset", 80'({chain_busy, desc_rd_valid}), 80'(0));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
